// File: rtl/ascii2nt_packer.sv
// Streaming ASCII-to-nucleotide converter that packs CHARS_IN-character beats into NT_OUT-slot words.
// Optional invalid-character counter on err_cnt is enabled by defining ASCII2NT_ERRCNT_EN.
module ascii2nt_packer #(
  parameter int CHARS_IN = 8,
  parameter int NT_OUT   = 32,
  parameter int CNT_W    = $clog2(NT_OUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*CHARS_IN-1:0]     in_data,
  input  logic [$clog2(CHARS_IN):0] in_cnt,
  input  logic                      in_last,
  input  logic                      in_complement,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [4*NT_OUT-1:0]       out_data,
  output logic [CNT_W-1:0]          out_cnt,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               err_cnt
);

  localparam int IN_CNT_W = $clog2(CHARS_IN) + 1;
  localparam int BEATS    = NT_OUT / CHARS_IN;

  typedef enum logic [3:0] {
    NT_N = 4'd0,
    NT_A = 4'd1,
    NT_C = 4'd2,
    NT_G = 4'd3,
    NT_T = 4'd4
  } nt_e;

  // OR-ing in 0x20 folds upper case onto lower case; no other byte lands on these letters.
  function automatic nt_e ascii2nt(input logic [7:0] ch, input logic comp);
    nt_e nt;
    nt_e nt_c;
    case (ch | 8'h20)
      8'h61:   nt = NT_A;
      8'h63:   nt = NT_C;
      8'h67:   nt = NT_G;
      8'h74:   nt = NT_T;
      default: nt = NT_N;
    endcase
    case (nt)
      NT_A:    nt_c = NT_T;
      NT_T:    nt_c = NT_A;
      NT_C:    nt_c = NT_G;
      NT_G:    nt_c = NT_C;
      default: nt_c = NT_N;
    endcase
    return comp ? nt_c : nt;
  endfunction

  function automatic logic is_nt(input logic [7:0] ch);
    case (ch | 8'h20)
      8'h61, 8'h63, 8'h67, 8'h6e, 8'h74: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  logic                 accept;
  logic                 retire;
  logic                 complete;
  logic [CNT_W-1:0]     fill_q;
  logic [CNT_W-1:0]     n;
  logic [CNT_W-1:0]     fill_sum;
  logic [4*NT_OUT-1:0]  word_d;
  nt_e                  code [CHARS_IN];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  // Illegal last-beat counts (0 or above CHARS_IN) fall back to a full beat.
  always_comb begin
    n = CNT_W'(CHARS_IN);
    if (in_last && in_cnt != '0 && in_cnt <= IN_CNT_W'(CHARS_IN))
      n = CNT_W'(in_cnt);
  end

  assign fill_sum = fill_q + n;
  assign complete = (fill_sum == CNT_W'(NT_OUT)) || in_last;

  // NOTE: every variable written here gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    word_d = (fill_q == '0) ? '0 : out_data;
    for (int i = 0; i < CHARS_IN; i++)
      code[i] = ascii2nt(in_data[8*i +: 8], in_complement);
    // The fill pointer is always beat-aligned, so only BEATS write positions exist.
    for (int b = 0; b < BEATS; b++) begin
      if (fill_q == CNT_W'(b * CHARS_IN)) begin
        for (int i = 0; i < CHARS_IN; i++) begin
          if (CNT_W'(i) < n)
            word_d[4*(b*CHARS_IN + i) +: 4] = code[i];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the accumulator doubles as the output register, so it is reset to keep unused slots at 0.
      out_data  <= '0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      fill_q    <= '0;
    end else begin
      if (retire)
        out_valid <= 1'b0;
      if (accept) begin
        out_data <= word_d;
        if (complete) begin
          out_valid <= 1'b1;
          out_cnt   <= fill_sum;
          out_last  <= in_last;
          fill_q    <= '0;
        end else begin
          fill_q <= fill_sum;
        end
      end
    end
  end

`ifdef ASCII2NT_ERRCNT_EN
  logic [IN_CNT_W-1:0] bad_cnt;
  logic [16:0]         err_sum;

  // A retiring last word clears the count first; the beat accepted on that edge still adds.
  always_comb begin
    bad_cnt = '0;
    for (int i = 0; i < CHARS_IN; i++) begin
      if (CNT_W'(i) < n && !is_nt(in_data[8*i +: 8]))
        bad_cnt = bad_cnt + IN_CNT_W'(1);
    end
    err_sum = (retire && out_last) ? 17'd0 : {1'b0, err_cnt};
    if (accept)
      err_sum = err_sum + 17'(bad_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ascii2nt_packer.sv
// Self-checking bench for ascii2nt_packer: directed steps plus randomized traffic against a
// queue-based word model. Error-count expectations follow ASCII2NT_ERRCNT_EN.
module tb_ascii2nt_packer;

  localparam int CI   = 8;
  localparam int NO   = 32;
  localparam int CW   = $clog2(NO) + 1;
  localparam int CIW  = $clog2(CI) + 1;
`ifdef ASCII2NT_ERRCNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [8*CI-1:0]  in_data;
  logic [CIW-1:0]   in_cnt;
  logic             in_last;
  logic             in_complement;
  logic             in_valid;
  logic             in_ready;
  logic [4*NO-1:0]  out_data;
  logic [CW-1:0]    out_cnt;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      err_cnt;

  ascii2nt_packer #(.CHARS_IN(CI), .NT_OUT(NO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
    .in_complement(in_complement), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           cnt;
    bit           last;
  } word_t;

  word_t exp_q[$];
  int    cur[$];
  int    err_m  = 0;
  int    total  = 0;
  int    passed = 0;
  int    failed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic byte unsigned upcase(input byte unsigned ch);
    return (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'd32 : ch;
  endfunction

  // Code = position in "ACGT" plus one, 0 for anything else; complement mirrors 1..4.
  function automatic int nt_code(input byte unsigned ch, input bit comp);
    string bases = "ACGT";
    int c = 0;
    for (int k = 0; k < 4; k++)
      if (upcase(ch) == bases[k]) c = k + 1;
    if (comp && c != 0) c = 5 - c;
    return c;
  endfunction

  function automatic bit is_bad(input byte unsigned ch);
    return nt_code(ch, 1'b0) == 0 && upcase(ch) != 8'h4e;
  endfunction

  task automatic model_accept();
    int    n;
    int    bad = 0;
    word_t w;
    n = (in_last && in_cnt != 0 && int'(in_cnt) <= CI) ? int'(in_cnt) : CI;
    for (int i = 0; i < n; i++) begin
      cur.push_back(nt_code(in_data[8*i +: 8], in_complement));
      if (is_bad(in_data[8*i +: 8])) bad++;
    end
    if (ERR_ON) err_m = (err_m + bad > 65535) ? 65535 : err_m + bad;
    if (cur.size() == NO || in_last) begin
      w.data = '0;
      foreach (cur[k]) w.data[4*k +: 4] = 4'(cur[k]);
      w.cnt  = cur.size();
      w.last = in_last;
      exp_q.push_back(w);
      cur.delete();
    end
  endtask

  // Called just after a falling edge with inputs set; checks, advances one clock, updates the model.
  task automatic cycle();
    bit ev, acc, hs;
    #1;
    ev = exp_q.size() != 0;
    check("out_valid", out_valid, ev);
    check("in_ready", in_ready, !ev || out_ready);
    check("err_cnt", err_cnt, err_m);
    if (ev) begin
      check("out_data", out_data, exp_q[0].data);
      check("out_cnt", out_cnt, exp_q[0].cnt);
      check("out_last", out_last, exp_q[0].last);
    end
    acc = in_valid && (!ev || out_ready);
    hs  = ev && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      err_m = 0;
    end else begin
      if (hs) begin
        if (exp_q[0].last) err_m = 0;
        void'(exp_q.pop_front());
      end
      if (acc) model_accept();
    end
    @(negedge clk);
  endtask

  task automatic drive(input string s, input bit last, input int cnt, input bit comp);
    in_data = '0;
    for (int i = 0; i < CI && i < s.len(); i++) in_data[8*i +: 8] = s[i];
    in_last       = last;
    in_cnt        = CIW'(cnt);
    in_complement = comp;
    in_valid      = 1'b1;
  endtask

  initial begin
    string pool = "ACGTNacgtnXz-*";
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0;
    in_last = 1'b0; in_complement = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Four full beats, last on the fourth.
    for (int b = 0; b < 4; b++) begin
      drive("ACGTACGT", b == 3, 8, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, {4{32'h4321_4321}});
    check("t1_cnt", out_cnt, 32);
    check("t1_last", out_last, 1'b1);
    cycle();

    // Complemented single last beat with one invalid character.
    drive("acgtnNxA", 1'b1, 8, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("t2_data", out_data, 128'h4000_1234);
    check("t2_cnt", out_cnt, 8);
    check("t2_err", err_cnt, ERR_ON ? 16'd1 : 16'd0);
    cycle();
    check("t2_err_clear", err_cnt, 16'd0);

    // Partial last beat: junk past in_cnt is neither packed nor counted.
    drive("GGGXXXXX", 1'b1, 3, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("t3_data", out_data, 128'h333);
    check("t3_cnt", out_cnt, 3);
    check("t3_err", err_cnt, 16'd0);
    cycle();

    // Backpressure, then retire and accept on the same edge.
    out_ready = 1'b0;
    drive("TTTTTTTT", 1'b1, 8, 1'b0);
    cycle();
    drive("CCCCCCCC", 1'b0, 8, 1'b0);
    repeat (5) begin
      check("t4_in_ready", in_ready, 1'b0);
      check("t4_hold", out_data, 128'h4444_4444);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("t4_retired", out_valid, 1'b0);
    check("t4_slot0", out_data, 128'h2222_2222);
    for (int b = 0; b < 3; b++) begin
      drive("CCCCCCCC", b == 2, 8, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    check("t4_word", out_data, {16{8'h22}});
    cycle();
    cycle();

    // Reset in the middle of a word.
    for (int b = 0; b < 2; b++) begin
      drive("ACGTXXGT", 1'b0, 8, 1'b0);
      cycle();
    end
    rst_n = 1'b0; in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t5_valid", out_valid, 1'b0);
    check("t5_err", err_cnt, 16'd0);
    for (int b = 0; b < 4; b++) begin
      drive("ACGTACGT", b == 3, 8, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    check("t5_cnt", out_cnt, 32);
    check("t5_data", out_data, {4{32'h4321_4321}});
    cycle();

    // Randomized traffic, including illegal last-beat counts.
    for (int c = 0; c < 400; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      in_valid  = $urandom_range(0, 3) != 0;
      in_last   = $urandom_range(0, 5) == 0;
      in_cnt    = CIW'($urandom_range(0, (1 << CIW) - 1));
      in_complement = $urandom_range(0, 1) == 1;
      for (int i = 0; i < CI; i++)
        in_data[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                        : pool[$urandom_range(0, pool.len() - 1)];
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;

    // Saturation of the invalid-character count.
    for (int b = 0; b < 8300; b++) begin
      drive("XXXXXXXX", 1'b0, 8, 1'b0);
      cycle();
    end
    check("t6_sat", err_cnt, ERR_ON ? 16'hFFFF : 16'd0);
    drive("XXXXXXXX", 1'b1, 8, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("t6_last", out_last, 1'b1);
    check("t6_sat_hold", err_cnt, ERR_ON ? 16'hFFFF : 16'd0);
    cycle();
    check("t6_cleared", err_cnt, 16'd0);
    check("t6_idle", out_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
